mbinit_param_responder: RTL and testbench
=========================================

# mbinit_param_responder

Responder side of the MBINIT.PARAM sideband exchange. Waits for the partner's `MBINIT_PARAM_configuration_req` and resolves the requested parameters against local capability. It then returns `MBINIT_PARAM_configuration_resp` with the negotiated values and latches the final parameters for the mainband. It runs in parallel with the PARAM initiator inside MBINIT, and both are gated by the same start enable.

## Interface
Parameters:
- LOCAL_MAX_DATA_RATE, 3'd5: highest local data-rate code; valid range 1..7.
- LOCAL_CLK_MODE_SUP, 2'b11: bit0 = strobe mode (0) supported; bit1 = continuous mode (1) supported.
- LOCAL_PHASE_SUP, 2'b11: bit0 = differential (0) supported; bit1 = quadrature (1) supported.
- TIMEOUT_CYCLES, 8000: WAIT_REQ cycles allowed before error; must be ≥2.

Ports:
- CLK  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- i_MBINIT_Start_en  in  1  level enable; low forces IDLE.
- i_RX_SbMessage  in  4  decoded received sideband message.
- i_msg_valid  in  1  i_RX_SbMessage and the RX fields are valid this cycle.
- i_RX_MaxDataRate  in  3  partner requested rate.
- i_RX_ClockMode  in  1  partner requested clock mode.
- i_RX_PhaseClock  in  1  partner requested clock phase.
- i_RX_VoltageSwing  in  5  partner TX swing, captured for status only.
- i_Busy_SideBand  in  1  sideband TX busy.
- i_falling_edge_busy  in  1  one-cycle pulse when busy falls.
- o_TX_SbMessage  out  4  message to send.
- o_ValidOutDatat_Module  out  1  send strobe.
- o_ValidDataFieldParameters  out  1  data field valid with strobe.
- o_MaxDataRate  out  3  negotiated rate in response.
- o_TX_ClockMode  out  1  negotiated clock mode in response.
- o_TX_PhaseClock  out  1  negotiated phase in response.
- o_RX_VoltageSwing  out  5  captured partner swing.
- o_Final_MaxDataRate  out  3  latched negotiated rate.
- o_Final_ClockMode  out  1  latched negotiated clock mode.
- o_Final_ClockPhase  out  1  latched negotiated clock phase.
- o_MBINIT_PARAM_resp_end  out  1  responder finished successfully.
- o_train_error_req  out  1  negotiation failed or timed out.

## Operation
- States: IDLE, WAIT_REQ, RESOLVE, SEND_RESP, WAIT_SENT, DONE, ERROR.
- IDLE → WAIT_REQ when i_MBINIT_Start_en = 1.
- WAIT_REQ:
  - When i_msg_valid = 1 and i_RX_SbMessage = 4'b0001: capture rate, mode, phase and swing, clear the timeout counter, go to RESOLVE.
  - Any other message is ignored.
  - The counter increments each cycle; reaching TIMEOUT_CYCLES-1 moves to ERROR.
- RESOLVE (exactly 1 cycle):
  - Rate = min(captured rate, LOCAL_MAX_DATA_RATE).
  - Mode is accepted only if LOCAL_CLK_MODE_SUP[captured mode] = 1.
  - Phase is accepted only if LOCAL_PHASE_SUP[captured phase] = 1.
  - Captured rate 0, unsupported mode or unsupported phase → ERROR.
  - Otherwise → SEND_RESP once i_Busy_SideBand = 0; the FSM holds in RESOLVE while busy.
- SEND_RESP (exactly 1 cycle):
  - o_ValidOutDatat_Module = 1, o_ValidDataFieldParameters = 1, o_TX_SbMessage = 4'b0010, response fields = resolved values.
  - Final registers load the resolved values.
  - → WAIT_SENT.
- WAIT_SENT → DONE on i_falling_edge_busy = 1 and i_Busy_SideBand = 0.
- DONE: o_MBINIT_PARAM_resp_end = 1, held.
- ERROR: o_train_error_req = 1, held.
- Start enable drop: i_MBINIT_Start_en = 0 in any state → IDLE next cycle. Strobe, end and error outputs clear. Final registers keep their values until reset or the next SEND_RESP.
- Simultaneous events: start-enable drop has priority over every other transition. A valid request in the same cycle as the timeout terminal count is accepted.

## Timing
- All outputs are registered and take effect the cycle after the transition condition.
- Reset: every output 0, counter 0, state IDLE.
- Latency, request accepted to send strobe: 2 cycles when the sideband is idle.
- The send strobe is exactly one cycle wide; it is never re-issued without a new request cycle through IDLE.
- Response fields are 0 whenever the send strobe is low.
- Counter width: $clog2(TIMEOUT_CYCLES); it saturates and never wraps.

## Structure
- Shared package `mbinit_pkg`:
  - Message codes: MBINIT_PARAM_configuration_req = 4'b0001, MBINIT_PARAM_configuration_resp = 4'b0010.
  - State enum.
  - Clock-mode and phase constants.
- Sub-module `mbinit_param_resolver`: combinational min and capability check, with outputs rate/mode/phase/ok. It is shared with the initiator-side checker.

## Test plan
- Start=1, request with rate 7, mode 1, phase 0; default parameters; busy idle → strobe 2 cycles later with msg 0010, rate 5, mode 1, phase 0. After the busy falling edge, end=1 and Final = 5/1/0.
- Request with rate 3 → response rate 3, not 5.
- LOCAL_CLK_MODE_SUP = 2'b01, request mode 1 → no strobe; error=1 held until start drops, then IDLE with all outputs 0.
- TIMEOUT_CYCLES = 16, no request → error=1 exactly 16 cycles after entering WAIT_REQ. A request arriving on the terminal-count cycle → normal response, no error.
- Busy=1 during RESOLVE for 5 cycles → strobe occurs the cycle after busy clears, single-cycle wide.
- Start dropped in WAIT_SENT, and separately rst asserted mid-exchange → IDLE; rst additionally zeroes the Final registers.

Source files
------------

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband message codes, FSM state encoding and
// clock-mode / clock-phase constants used by the PARAM initiator and responder.
package mbinit_pkg;

    localparam logic [3:0] MBINIT_PARAM_configuration_req  = 4'b0001;
    localparam logic [3:0] MBINIT_PARAM_configuration_resp = 4'b0010;

    localparam logic CLK_MODE_STROBE     = 1'b0;
    localparam logic CLK_MODE_CONTINUOUS = 1'b1;
    localparam logic PHASE_DIFFERENTIAL  = 1'b0;
    localparam logic PHASE_QUADRATURE    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_REQ  = 3'd1,
        ST_RESOLVE   = 3'd2,
        ST_SEND_RESP = 3'd3,
        ST_WAIT_SENT = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } mbinit_state_e;

endpackage

// File: rtl/mbinit_param_resolver.sv
// Combinational negotiation of requested PARAM values against local capability:
// rate is clamped to the local maximum, mode and phase must be locally supported.
module mbinit_param_resolver #(
    parameter logic [2:0] LOCAL_MAX_DATA_RATE = 3'd5,
    parameter logic [1:0] LOCAL_CLK_MODE_SUP  = 2'b11,
    parameter logic [1:0] LOCAL_PHASE_SUP     = 2'b11
) (
    input  logic [2:0] req_rate,
    input  logic       req_mode,
    input  logic       req_phase,
    output logic [2:0] rate,
    output logic       mode,
    output logic       phase,
    output logic       ok
);

    assign rate  = (req_rate > LOCAL_MAX_DATA_RATE) ? LOCAL_MAX_DATA_RATE : req_rate;
    assign mode  = req_mode;
    assign phase = req_phase;
    // A zero rate code means the partner offered nothing usable.
    assign ok    = (req_rate != 3'd0) && LOCAL_CLK_MODE_SUP[req_mode] && LOCAL_PHASE_SUP[req_phase];

endmodule

// File: rtl/mbinit_param_responder.sv
// Responder side of MBINIT.PARAM: waits for the partner's configuration request,
// resolves it, sends the configuration response and latches the final parameters.
module mbinit_param_responder
    import mbinit_pkg::*;
#(
    parameter logic [2:0] LOCAL_MAX_DATA_RATE = 3'd5,
    parameter logic [1:0] LOCAL_CLK_MODE_SUP  = 2'b11,
    parameter logic [1:0] LOCAL_PHASE_SUP     = 2'b11,
    parameter int         TIMEOUT_CYCLES      = 8000
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          i_MBINIT_Start_en,
    input  logic [3:0]    i_RX_SbMessage,
    input  logic          i_msg_valid,
    input  logic [2:0]    i_RX_MaxDataRate,
    input  logic          i_RX_ClockMode,
    input  logic          i_RX_PhaseClock,
    input  logic [4:0]    i_RX_VoltageSwing,
    input  logic          i_Busy_SideBand,
    input  logic          i_falling_edge_busy,
    output logic [3:0]    o_TX_SbMessage,
    output logic          o_ValidOutDatat_Module,
    output logic          o_ValidDataFieldParameters,
    output logic [2:0]    o_MaxDataRate,
    output logic          o_TX_ClockMode,
    output logic          o_TX_PhaseClock,
    output logic [4:0]    o_RX_VoltageSwing,
    output logic [2:0]    o_Final_MaxDataRate,
    output logic          o_Final_ClockMode,
    output logic          o_Final_ClockPhase,
    output logic          o_MBINIT_PARAM_resp_end,
    output logic          o_train_error_req,
    output mbinit_state_e debug_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    mbinit_state_e    state;
    logic [CNT_W-1:0] count;
    logic [2:0]       cap_rate;
    logic             cap_mode;
    logic             cap_phase;
    logic [2:0]       res_rate;
    logic             res_mode;
    logic             res_phase;
    logic             res_ok;

    assign debug_state = state;

    mbinit_param_resolver #(
        .LOCAL_MAX_DATA_RATE (LOCAL_MAX_DATA_RATE),
        .LOCAL_CLK_MODE_SUP  (LOCAL_CLK_MODE_SUP),
        .LOCAL_PHASE_SUP     (LOCAL_PHASE_SUP)
    ) u_resolver (
        .req_rate  (cap_rate),
        .req_mode  (cap_mode),
        .req_phase (cap_phase),
        .rate      (res_rate),
        .mode      (res_mode),
        .phase     (res_phase),
        .ok        (res_ok)
    );

    // Sideband handshake: a send is a one-cycle strobe issued only while the
    // sideband is not busy; completion is the busy falling-edge pulse with busy low.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state                      <= ST_IDLE;
            count                      <= '0;
            cap_rate                   <= 3'd0;
            cap_mode                   <= 1'b0;
            cap_phase                  <= 1'b0;
            o_TX_SbMessage             <= 4'd0;
            o_ValidOutDatat_Module     <= 1'b0;
            o_ValidDataFieldParameters <= 1'b0;
            o_MaxDataRate              <= 3'd0;
            o_TX_ClockMode             <= 1'b0;
            o_TX_PhaseClock            <= 1'b0;
            o_RX_VoltageSwing          <= 5'd0;
            o_Final_MaxDataRate        <= 3'd0;
            o_Final_ClockMode          <= 1'b0;
            o_Final_ClockPhase         <= 1'b0;
            o_MBINIT_PARAM_resp_end    <= 1'b0;
            o_train_error_req          <= 1'b0;
        end else begin
            o_TX_SbMessage             <= 4'd0;
            o_ValidOutDatat_Module     <= 1'b0;
            o_ValidDataFieldParameters <= 1'b0;
            o_MaxDataRate              <= 3'd0;
            o_TX_ClockMode             <= 1'b0;
            o_TX_PhaseClock            <= 1'b0;
            if (!i_MBINIT_Start_en) begin
                // Final parameters deliberately survive an enable drop.
                state                   <= ST_IDLE;
                count                   <= '0;
                o_RX_VoltageSwing       <= 5'd0;
                o_MBINIT_PARAM_resp_end <= 1'b0;
                o_train_error_req       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        count <= '0;
                        state <= ST_WAIT_REQ;
                    end
                    ST_WAIT_REQ: begin
                        if (i_msg_valid && (i_RX_SbMessage == MBINIT_PARAM_configuration_req)) begin
                            cap_rate          <= i_RX_MaxDataRate;
                            cap_mode          <= i_RX_ClockMode;
                            cap_phase         <= i_RX_PhaseClock;
                            o_RX_VoltageSwing <= i_RX_VoltageSwing;
                            count             <= '0;
                            state             <= ST_RESOLVE;
                        end else if (count == CNT_TERMINAL) begin
                            o_train_error_req <= 1'b1;
                            state             <= ST_ERROR;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    ST_RESOLVE: begin
                        if (!res_ok) begin
                            o_train_error_req <= 1'b1;
                            state             <= ST_ERROR;
                        end else if (!i_Busy_SideBand) begin
                            o_TX_SbMessage             <= MBINIT_PARAM_configuration_resp;
                            o_ValidOutDatat_Module     <= 1'b1;
                            o_ValidDataFieldParameters <= 1'b1;
                            o_MaxDataRate              <= res_rate;
                            o_TX_ClockMode             <= res_mode;
                            o_TX_PhaseClock            <= res_phase;
                            o_Final_MaxDataRate        <= res_rate;
                            o_Final_ClockMode          <= res_mode;
                            o_Final_ClockPhase         <= res_phase;
                            state                      <= ST_SEND_RESP;
                        end
                    end
                    ST_SEND_RESP: state <= ST_WAIT_SENT;
                    ST_WAIT_SENT: begin
                        if (i_falling_edge_busy && !i_Busy_SideBand) begin
                            o_MBINIT_PARAM_resp_end <= 1'b1;
                            state                   <= ST_DONE;
                        end
                    end
                    ST_DONE:  state <= ST_DONE;
                    ST_ERROR: state <= ST_ERROR;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mbinit_param_responder.sv
// Directed bench for mbinit_param_responder: instance a has full capability,
// instance b lacks continuous clock mode; both use a 16-cycle request timeout.
module tb_mbinit_param_responder;
    import mbinit_pkg::*;

    logic clk = 1'b0;
    logic rst, start, msg_valid, busy, fall, rx_mode, rx_phase;
    logic [3:0] rx_msg;
    logic [2:0] rx_rate;
    logic [4:0] rx_swing;

    logic [3:0] a_msg, b_msg;
    logic a_strobe, b_strobe, a_dfv, b_dfv, a_mode, b_mode, a_phase, b_phase;
    logic [2:0] a_rate, b_rate, a_frate, b_frate;
    logic [4:0] a_swing, b_swing;
    logic a_fmode, b_fmode, a_fphase, b_fphase, a_end, b_end, a_err, b_err;
    mbinit_state_e a_state, b_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mbinit_param_responder #(.TIMEOUT_CYCLES(16)) dut_a (
        .CLK(clk), .rst(rst), .i_MBINIT_Start_en(start), .i_RX_SbMessage(rx_msg),
        .i_msg_valid(msg_valid), .i_RX_MaxDataRate(rx_rate), .i_RX_ClockMode(rx_mode),
        .i_RX_PhaseClock(rx_phase), .i_RX_VoltageSwing(rx_swing), .i_Busy_SideBand(busy),
        .i_falling_edge_busy(fall), .o_TX_SbMessage(a_msg), .o_ValidOutDatat_Module(a_strobe),
        .o_ValidDataFieldParameters(a_dfv), .o_MaxDataRate(a_rate), .o_TX_ClockMode(a_mode),
        .o_TX_PhaseClock(a_phase), .o_RX_VoltageSwing(a_swing), .o_Final_MaxDataRate(a_frate),
        .o_Final_ClockMode(a_fmode), .o_Final_ClockPhase(a_fphase),
        .o_MBINIT_PARAM_resp_end(a_end), .o_train_error_req(a_err), .debug_state(a_state)
    );

    mbinit_param_responder #(.LOCAL_CLK_MODE_SUP(2'b01), .TIMEOUT_CYCLES(16)) dut_b (
        .CLK(clk), .rst(rst), .i_MBINIT_Start_en(start), .i_RX_SbMessage(rx_msg),
        .i_msg_valid(msg_valid), .i_RX_MaxDataRate(rx_rate), .i_RX_ClockMode(rx_mode),
        .i_RX_PhaseClock(rx_phase), .i_RX_VoltageSwing(rx_swing), .i_Busy_SideBand(busy),
        .i_falling_edge_busy(fall), .o_TX_SbMessage(b_msg), .o_ValidOutDatat_Module(b_strobe),
        .o_ValidDataFieldParameters(b_dfv), .o_MaxDataRate(b_rate), .o_TX_ClockMode(b_mode),
        .o_TX_PhaseClock(b_phase), .o_RX_VoltageSwing(b_swing), .o_Final_MaxDataRate(b_frate),
        .o_Final_ClockMode(b_fmode), .o_Final_ClockPhase(b_fphase),
        .o_MBINIT_PARAM_resp_end(b_end), .o_train_error_req(b_err), .debug_state(b_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [2:0] rate, input logic mode, input logic phase,
                            input logic [4:0] swing);
        rx_msg    = MBINIT_PARAM_configuration_req;
        msg_valid = 1'b1;
        rx_rate   = rate;
        rx_mode   = mode;
        rx_phase  = phase;
        rx_swing  = swing;
        step();
        rx_msg    = 4'd0;
        msg_valid = 1'b0;
        rx_rate   = 3'd0;
        rx_mode   = 1'b0;
        rx_phase  = 1'b0;
        rx_swing  = 5'd0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; msg_valid = 1'b0; busy = 1'b0; fall = 1'b0;
        rx_msg = 4'd0; rx_rate = 3'd0; rx_mode = 1'b0; rx_phase = 1'b0; rx_swing = 5'd0;
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst_state", a_state, ST_IDLE);
        check("rst_outputs", {a_msg, a_strobe, a_dfv, a_rate, a_mode, a_phase, a_swing,
              a_frate, a_fmode, a_fphase, a_end, a_err}, 32'd0);

        // rate 7 / mode 1 / phase 0 clamps to 5; b rejects continuous mode
        start = 1'b1;
        step();
        check("enter_wait_req", a_state, ST_WAIT_REQ);
        send_req(3'd7, 1'b1, 1'b0, 5'h15);
        check("resolve_no_strobe", a_strobe, 1'b0);
        step();
        check("strobe", a_strobe, 1'b1);
        check("resp_fields", {a_msg, a_dfv, a_rate, a_mode, a_phase}, {4'b0010, 1'b1, 3'd5, 1'b1, 1'b0});
        check("swing_capture", a_swing, 5'h15);
        check("b_error", b_err, 1'b1);
        check("b_no_strobe", b_strobe, 1'b0);
        step();
        check("strobe_single", a_strobe, 1'b0);
        check("fields_zero", {a_msg, a_dfv, a_rate, a_mode, a_phase}, 32'd0);
        busy = 1'b1;
        step();
        check("wait_sent_no_end", a_end, 1'b0);
        busy = 1'b0;
        fall = 1'b1;
        step();
        fall = 1'b0;
        check("resp_end", a_end, 1'b1);
        step();
        check("resp_end_held", a_end, 1'b1);
        check("finals_5_1_0", {a_frate, a_fmode, a_fphase}, {3'd5, 1'b1, 1'b0});
        check("b_error_held", b_err, 1'b1);
        start = 1'b0;
        step();
        check("drop_idle", a_state, ST_IDLE);
        check("drop_end_clear", a_end, 1'b0);
        check("finals_kept", {a_frate, a_fmode, a_fphase}, {3'd5, 1'b1, 1'b0});
        check("b_idle", b_state, ST_IDLE);
        check("b_all_zero", {b_msg, b_strobe, b_dfv, b_rate, b_mode, b_phase, b_swing,
              b_frate, b_fmode, b_fphase, b_end, b_err}, 32'd0);

        // rate below local max passes through
        start = 1'b1;
        step();
        send_req(3'd3, 1'b0, 1'b1, 5'h03);
        step();
        check("rate3_strobe", a_strobe, 1'b1);
        check("rate3_fields", {a_rate, a_mode, a_phase}, {3'd3, 1'b0, 1'b1});
        start = 1'b0;
        step();

        // timeout: error exactly 16 cycles after entering WAIT_REQ
        start = 1'b1;
        step();
        repeat (15) step();
        check("timeout_not_yet", a_err, 1'b0);
        check("timeout_still_wait", a_state, ST_WAIT_REQ);
        step();
        check("timeout_error", a_err, 1'b1);
        start = 1'b0;
        step();
        check("timeout_error_clear", a_err, 1'b0);

        // request on the terminal-count cycle wins over the timeout
        start = 1'b1;
        step();
        repeat (15) step();
        send_req(3'd4, 1'b1, 1'b1, 5'h0a);
        check("tc_req_no_error", a_err, 1'b0);
        check("tc_req_resolve", a_state, ST_RESOLVE);
        step();
        check("tc_req_strobe", a_strobe, 1'b1);
        check("tc_req_fields", {a_rate, a_mode, a_phase}, {3'd4, 1'b1, 1'b1});
        start = 1'b0;
        step();

        // busy holds RESOLVE; strobe the cycle after busy clears
        start = 1'b1;
        step();
        busy = 1'b1;
        send_req(3'd6, 1'b0, 1'b0, 5'h1f);
        repeat (4) step();
        check("busy_hold_no_strobe", a_strobe, 1'b0);
        check("busy_hold_state", a_state, ST_RESOLVE);
        busy = 1'b0;
        step();
        check("busy_release_strobe", a_strobe, 1'b1);
        check("busy_release_rate", a_rate, 3'd5);
        step();
        check("busy_strobe_single", a_strobe, 1'b0);
        check("busy_wait_sent", a_state, ST_WAIT_SENT);

        // enable drop in WAIT_SENT
        start = 1'b0;
        step();
        check("drop_wait_sent_idle", a_state, ST_IDLE);
        check("drop_finals_kept", {a_frate, a_fmode, a_fphase}, {3'd5, 1'b0, 1'b0});

        // reset mid-exchange zeroes the finals
        start = 1'b1;
        step();
        send_req(3'd2, 1'b1, 1'b0, 5'h07);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_idle", a_state, ST_IDLE);
        check("rst_mid_finals", {a_frate, a_fmode, a_fphase, a_swing}, 32'd0);
        step();
        check("rst_mid_no_strobe", a_strobe, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
